tile_renderer: RTL and testbench

Pixel pipeline that turns the 40×30 tile map plus 4×4 sprite bitmaps into 24-bit RGB for the VGA driver. It sits between the raster counters/tile-map RAM and the `vga` driver. It receives pixel coordinates every clock, fetches the tile code through a synchronous-read map port, expands the sprite, and emits colour with the syncs delayed to match. It also latches the pac-man animation frame once per frame, so the sprite never tears.

---
 rtl/tile_renderer_if.sv | 42 ++++
 rtl/tile_renderer.sv | 248 ++++++++++++++++++++++++
 tb/tb_tile_renderer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_renderer_if.sv
// ---------------------------------------------------------------------------
// tile_renderer_if
//
// Bundles every tile_renderer signal except clock and reset.
//
//   Pixel input  : in_valid, x[9:0], y[9:0], hs_in, vs_in
//   Sprite input : pac_dir[2:0], waka
//   Map port     : map_addr[10:0] (renderer -> RAM),
//                  map_data[3:0]  (RAM -> renderer, one clock after map_addr)
//   Colour output: red/green/blue[7:0], out_valid, hs_out, vs_out
//
// The "master" side is the surrounding system: the raster counters, the
// sprite controls and the tile-map RAM read port. The "slave" side is the
// renderer itself.
// ---------------------------------------------------------------------------
interface tile_renderer_if;
    logic        in_valid;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs_in;
    logic        vs_in;
    logic [2:0]  pac_dir;
    logic        waka;
    logic [10:0] map_addr;
    logic [3:0]  map_data;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        out_valid;
    logic        hs_out;
    logic        vs_out;

    modport master (
        output in_valid, x, y, hs_in, vs_in, pac_dir, waka, map_data,
        input  map_addr, red, green, blue, out_valid, hs_out, vs_out
    );

    modport slave (
        input  in_valid, x, y, hs_in, vs_in, pac_dir, waka, map_data,
        output map_addr, red, green, blue, out_valid, hs_out, vs_out
    );
endinterface

// File: rtl/tile_renderer.sv
// ---------------------------------------------------------------------------
// tile_renderer
//
// Three-stage pixel pipeline between the raster counters / tile-map RAM and
// the VGA driver. One pixel per clock, no stalls.
//
//   S1: register the coordinate and syncs, decide whether the pixel is in
//       the active area and issue the tile-map read address.
//   S2: the tile code returns from the synchronous-read map RAM; the colour
//       is decoded combinationally from the code and the pixel's position
//       inside its 16x16 tile (4x4 sprite cells of 4x4 pixels each).
//   S3: the colour, out_valid and the syncs are registered together.
//
// The pac-man bitmap is chosen once per frame, on the active pixel (0,0),
// and then held so that the sprite cannot change shape halfway down the
// screen.
//
// Ports:
//   clk   : pixel clock (VGA_CLK domain)
//   reset : asynchronous, active-high; outputs go black, syncs inactive (1)
//   bus   : tile_renderer_if.slave (pixel in, map port, colour out)
// ---------------------------------------------------------------------------
module tile_renderer #(
    parameter int MAP_W    = 40,
    parameter int MAP_H    = 30,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic            clk,
    input  logic            reset,
    tile_renderer_if.slave  bus
);

    localparam logic [9:0]  H_LIM      = 10'(H_ACTIVE);
    localparam logic [9:0]  V_LIM      = 10'(V_ACTIVE);
    localparam logic [10:0] ROW_STRIDE = 11'(MAP_W);
    localparam logic [10:0] MAP_SIZE   = 11'(MAP_W * MAP_H);

    // 4x4 sprite bitmaps; bit p is sprite cell p = col + 4*row.
    localparam logic [15:0] BM_IDLE    = 16'h6FF6;
    localparam logic [15:0] BM_RIGHT   = 16'h6776;
    localparam logic [15:0] BM_LEFT    = 16'h6EE6;
    localparam logic [15:0] BM_UP      = 16'h6FF0;
    localparam logic [15:0] BM_DOWN    = 16'h0FF6;
    localparam logic [15:0] SUPER_DOT  = 16'h0660;
    localparam logic [15:0] GHOST_BODY = 16'hDFF6;
    localparam logic [15:0] GHOST_EYE  = 16'h0060;

    typedef enum logic [2:0] {
        SPR_IDLE,
        SPR_RIGHT,
        SPR_LEFT,
        SPR_UP,
        SPR_DOWN
    } spr_sel_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t C_BLACK  = 24'h000000;
    localparam rgb_t C_WHITE  = 24'hFFFFFF;
    localparam rgb_t C_WALL   = 24'h0000FA;
    localparam rgb_t C_YELLOW = 24'hFFFF00;
    localparam rgb_t C_ORANGE = 24'hFF8000;
    localparam rgb_t C_CYAN   = 24'h00FFFF;
    localparam rgb_t C_RED    = 24'hFF0000;
    localparam rgb_t C_PINK   = 24'hFFBEC8;

    // ------------------------------------------------------------------
    // S1 combinational: active test, map address, frame-start sprite pick
    // ------------------------------------------------------------------
    logic        act_in;
    logic        frame_start;
    logic [10:0] addr_next;
    spr_sel_t    spr_next;

    always_comb begin
        act_in      = bus.in_valid && (bus.x < H_LIM) && (bus.y < V_LIM);
        frame_start = act_in && (bus.x == 10'd0) && (bus.y == 10'd0);
        // Tile row/column are the coordinate divided by the 16-pixel tile.
        addr_next   = {5'd0, bus.y[9:4]} * ROW_STRIDE + {5'd0, bus.x[9:4]};
    end

    // NOTE: every signal assigned in an always_comb gets a default on the
    // first line, so no path through the case statements can leave it
    // unassigned and infer a latch.
    always_comb begin
        spr_next = SPR_IDLE;
        if (!bus.waka) begin
            unique case (bus.pac_dir)
                3'd1:    spr_next = SPR_RIGHT;
                3'd2:    spr_next = SPR_LEFT;
                3'd3:    spr_next = SPR_UP;
                3'd4:    spr_next = SPR_DOWN;
                default: spr_next = SPR_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // S1 registers
    // ------------------------------------------------------------------
    // Only the position inside the tile is needed after address generation.
    logic [3:0] xm1;
    logic [3:0] ym1;
    logic       act1;
    logic       hs1;
    logic       vs1;
    spr_sel_t   spr_sel;   // frame-latched pac-man bitmap selection
    spr_sel_t   sel1;      // selection travelling with this pixel

    // NOTE: state is written with non-blocking assignments only, and the
    // reset is in the sensitivity list so it acts without waiting for a
    // clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xm1          <= '0;
            ym1          <= '0;
            act1         <= 1'b0;
            hs1          <= 1'b1;
            vs1          <= 1'b1;
            bus.map_addr <= '0;
            spr_sel      <= SPR_IDLE;
            sel1         <= SPR_IDLE;
        end else begin
            xm1          <= bus.x[3:0];
            ym1          <= bus.y[3:0];
            act1         <= act_in;
            hs1          <= bus.hs_in;
            vs1          <= bus.vs_in;
            bus.map_addr <= (act_in && (addr_next < MAP_SIZE)) ? addr_next : '0;
            if (frame_start) begin
                spr_sel <= spr_next;
            end
            // Pixel (0,0) already uses the selection it latches; the
            // pixels still in flight from the previous frame keep theirs.
            sel1 <= frame_start ? spr_next : spr_sel;
        end
    end

    // ------------------------------------------------------------------
    // S2 registers: aligned with map_data returning from the RAM
    // ------------------------------------------------------------------
    logic [3:0] xm2;
    logic [3:0] ym2;
    logic       act2;
    logic       hs2;
    logic       vs2;
    spr_sel_t   sel2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xm2  <= '0;
            ym2  <= '0;
            act2 <= 1'b0;
            hs2  <= 1'b1;
            vs2  <= 1'b1;
            sel2 <= SPR_IDLE;
        end else begin
            xm2  <= xm1;
            ym2  <= ym1;
            act2 <= act1;
            hs2  <= hs1;
            vs2  <= vs1;
            sel2 <= sel1;
        end
    end

    // ------------------------------------------------------------------
    // S2 combinational: colour decode
    // ------------------------------------------------------------------
    logic [3:0]  pos;        // sprite cell 0..15 inside the tile
    logic [15:0] pac_bm;
    logic        on_border;
    logic        in_dot;
    rgb_t        rgb_next;

    always_comb begin
        // Each sprite cell covers 4x4 pixels: cell = col + 4*row.
        pos       = {ym2[3:2], xm2[3:2]};
        // Wall border is the outer two pixels: x%16 in {0,1,14,15}.
        on_border = (xm2[3:1] == 3'b000) || (xm2[3:1] == 3'b111) ||
                    (ym2[3:1] == 3'b000) || (ym2[3:1] == 3'b111);
        in_dot    = (xm2 >= 4'd6) && (xm2 <= 4'd9) &&
                    (ym2 >= 4'd6) && (ym2 <= 4'd9);
    end

    always_comb begin
        pac_bm = BM_IDLE;
        unique case (sel2)
            SPR_RIGHT: pac_bm = BM_RIGHT;
            SPR_LEFT:  pac_bm = BM_LEFT;
            SPR_UP:    pac_bm = BM_UP;
            SPR_DOWN:  pac_bm = BM_DOWN;
            default:   pac_bm = BM_IDLE;
        endcase
    end

    always_comb begin
        rgb_next = C_BLACK;
        if (act2) begin
            unique case (bus.map_data)
                4'd1: if (on_border)         rgb_next = C_WALL;
                4'd2: if (in_dot)            rgb_next = C_WHITE;
                4'd3: if (SUPER_DOT[pos])    rgb_next = C_WHITE;
                4'd4: if (pac_bm[pos])       rgb_next = C_YELLOW;
                4'd5, 4'd6, 4'd7, 4'd8: begin
                    if (GHOST_EYE[pos]) begin
                        rgb_next = C_WHITE;
                    end else if (GHOST_BODY[pos]) begin
                        unique case (bus.map_data)
                            4'd5:    rgb_next = C_ORANGE;
                            4'd6:    rgb_next = C_CYAN;
                            4'd7:    rgb_next = C_RED;
                            default: rgb_next = C_PINK;
                        endcase
                    end
                end
                default: rgb_next = C_BLACK;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // S3 registers: colour with its syncs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.red       <= '0;
            bus.green     <= '0;
            bus.blue      <= '0;
            bus.out_valid <= 1'b0;
            bus.hs_out    <= 1'b1;
            bus.vs_out    <= 1'b1;
        end else begin
            bus.red       <= rgb_next.r;
            bus.green     <= rgb_next.g;
            bus.blue      <= rgb_next.b;
            bus.out_valid <= act2;
            bus.hs_out    <= hs2;
            bus.vs_out    <= vs2;
        end
    end

endmodule

// File: tb/tb_tile_renderer.sv
// ---------------------------------------------------------------------------
// tb_tile_renderer
//
// Directed bench for tile_renderer. A tile-map RAM model answers map_addr
// one clock later. Every driven pixel schedules its expected map_addr
// (1 clk later) and its expected colour/valid/syncs (3 clk later) from a
// plain-arithmetic model of the colour rules; a negedge process compares
// the DUT with those expectations. Hand-computed literals pin the model on
// the key cases.
// ---------------------------------------------------------------------------
module tb_tile_renderer;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    tile_renderer_if bus();

    tile_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Tile-map RAM with a registered read.
    logic [3:0] mem [0:1199];
    always @(posedge clk) bus.map_data <= mem[bus.map_addr];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] m_bm = 16'h6FF6;      // model's frame-latched pac bitmap
    logic [26:0] exp_out [int];        // {rgb, out_valid, hs, vs}
    logic [10:0] exp_map [int];
    logic [26:0] h_out   [int];        // DUT history, for literal checks
    logic [10:0] h_map   [int];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] bitmap_for(input logic [2:0] dir, input logic wk);
        if (wk) return 16'h6FF6;
        case (dir)
            3'd1:    return 16'h6776;
            3'd2:    return 16'h6EE6;
            3'd3:    return 16'h6FF0;
            3'd4:    return 16'h0FF6;
            default: return 16'h6FF6;
        endcase
    endfunction

    function automatic logic [23:0] model_rgb(input int xm, input int ym, input bit act,
                                              input int tile, input logic [15:0] bm);
        int          pos;
        logic [15:0] sd;
        logic [15:0] body;
        logic [15:0] eye;
        sd   = 16'h0660;
        body = 16'hDFF6;
        eye  = 16'h0060;
        pos  = xm / 4 + (ym / 4) * 4;
        if (!act) return 24'h0;
        case (tile)
            1: if (xm <= 1 || xm >= 14 || ym <= 1 || ym >= 14) return 24'h0000FA;
            2: if (xm >= 6 && xm <= 9 && ym >= 6 && ym <= 9) return 24'hFFFFFF;
            3: if (sd[pos]) return 24'hFFFFFF;
            4: if (bm[pos]) return 24'hFFFF00;
            5, 6, 7, 8: begin
                if (eye[pos]) return 24'hFFFFFF;
                if (body[pos]) begin
                    case (tile)
                        5:       return 24'hFF8000;
                        6:       return 24'h00FFFF;
                        7:       return 24'hFF0000;
                        default: return 24'hFFBEC8;
                    endcase
                end
            end
            default: ;
        endcase
        return 24'h0;
    endfunction

    // Drive one pixel for one clock and schedule what it must produce.
    task automatic pix(input int px, input int py, input bit v, input bit hs,
                       input bit vs, output int k);
        bit act;
        int addr;
        k           = cyc;
        bus.x       = px[9:0];
        bus.y       = py[9:0];
        bus.in_valid = v;
        bus.hs_in   = hs;
        bus.vs_in   = vs;
        act  = v && px < 640 && py < 480;
        addr = act ? (py / 16) * 40 + px / 16 : 0;
        if (act && px == 0 && py == 0) m_bm = bitmap_for(bus.pac_dir, bus.waka);
        exp_map[k + 1] = 11'(addr);
        exp_out[k + 3] = {model_rgb(px % 16, py % 16, act, int'(mem[addr]), m_bm),
                          act, hs, vs};
        @(posedge clk);
        #1;
    endtask

    task automatic px_on(input int px, input int py, output int k);
        pix(px, py, 1'b1, 1'b1, 1'b1, k);
    endtask

    task automatic idle(input int n);
        int k;
        for (int i = 0; i < n; i++) pix(0, 0, 1'b0, 1'b1, 1'b1, k);
    endtask

    // Return just after the posedge that ends cycle 'target'.
    task automatic wait_until(input int target);
        int n;
        n = 0;
        while (cyc <= target && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (cyc <= target) check("wait_timeout", 32'(cyc), 32'(target + 1));
    endtask

    task automatic lit(input string name, input int c, input logic [23:0] rgb,
                       input bit ov);
        check(name, 32'(h_out[c][26:2]), 32'({rgb, ov}));
    endtask

    task automatic lit_map(input string name, input int c, input int addr);
        check(name, 32'(h_map[c]), 32'(addr));
    endtask

    // Compare process.
    always @(negedge clk) begin
        h_out[cyc] = {bus.red, bus.green, bus.blue, bus.out_valid, bus.hs_out, bus.vs_out};
        h_map[cyc] = bus.map_addr;
        if (!reset) begin
            if (exp_map.exists(cyc)) begin
                check("map_addr", 32'(bus.map_addr), 32'(exp_map[cyc]));
                exp_map.delete(cyc);
            end
            if (exp_out.exists(cyc)) begin
                check("pixel_out", 32'(h_out[cyc]), 32'(exp_out[cyc]));
                exp_out.delete(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, ka, kb, kc, kd, ke, kf, kr;
        int ys [5];
        ys = '{16, 17, 22, 25, 30};

        for (int i = 0; i < 1200; i++) mem[i] = 4'd0;
        for (int i = 0; i < 16; i++) mem[40 + i] = 4'(i);   // row 1: every code
        mem[3]    = 4'd7;                                    // red ghost
        mem[82]   = 4'd4;                                    // pac-man
        mem[1199] = 4'd1;                                    // last tile: wall

        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        bus.hs_in    = 1'b1;
        bus.vs_in    = 1'b1;
        bus.pac_dir  = 3'd0;
        bus.waka     = 1'b0;

        // Reset state.
        #1 reset = 1'b1;
        #7;
        check("reset_out", 32'({bus.red, bus.green, bus.blue, bus.out_valid,
                                bus.hs_out, bus.vs_out}), 32'({24'h0, 3'b011}));
        check("reset_map", 32'(bus.map_addr), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Address generation.
        px_on(100, 50, k);
        idle(4);
        wait_until(k + 3);
        lit_map("addr_100_50", k + 1, 126);

        // Inactive pixel beyond the right edge.
        pix(700, 10, 1'b1, 1'b1, 1'b1, k);
        idle(4);
        wait_until(k + 3);
        lit_map("inactive_addr", k + 1, 0);
        lit("inactive_out", k + 3, 24'h0, 1'b0);

        // Wall edge and wall interior.
        px_on(16, 20, ka);
        px_on(24, 24, kb);
        idle(4);
        wait_until(kb + 3);
        lit("wall_edge", ka + 3, 24'h0000FA, 1'b1);
        lit("wall_inner", kb + 3, 24'h0, 1'b1);

        // Pac-man frame latch: right, then a mid-frame change to left.
        bus.pac_dir = 3'd1;
        bus.waka    = 1'b0;
        px_on(0, 0, k);
        px_on(45, 37, ka);
        px_on(37, 37, kb);
        bus.pac_dir = 3'd2;
        px_on(45, 37, kc);
        idle(4);
        wait_until(kc + 3);
        lit("pac_right_pos7", ka + 3, 24'h0, 1'b1);
        lit("pac_right_pos5", kb + 3, 24'hFFFF00, 1'b1);
        lit("pac_midframe_pos7", kc + 3, 24'h0, 1'b1);

        // Next frame picks up left.
        px_on(0, 0, k);
        px_on(45, 37, kd);
        // waka forces idle, then down without waka.
        bus.pac_dir = 3'd4;
        bus.waka    = 1'b1;
        px_on(0, 0, k);
        px_on(37, 45, ke);
        bus.waka    = 1'b0;
        px_on(0, 0, k);
        px_on(37, 45, kf);
        idle(4);
        wait_until(kf + 3);
        lit("pac_left_pos7", kd + 3, 24'hFFFF00, 1'b1);
        lit("pac_waka_pos13", ke + 3, 24'hFFFF00, 1'b1);
        lit("pac_down_pos13", kf + 3, 24'h0, 1'b1);

        // Red ghost: eye, body, outside the body.
        px_on(53, 5, ka);
        px_on(49, 5, kb);
        px_on(48, 0, kc);
        idle(4);
        wait_until(kc + 3);
        lit("ghost_eye", ka + 3, 24'hFFFFFF, 1'b1);
        lit("ghost_body", kb + 3, 24'hFF0000, 1'b1);
        lit("ghost_clear", kc + 3, 24'h0, 1'b1);

        // Back-to-back sweep over every tile code with sync activity.
        for (int yi = 0; yi < 5; yi++) begin
            for (int xi = 0; xi < 256; xi++) begin
                pix(xi, ys[yi], 1'b1, (xi % 37) != 0, yi != 2, k);
            end
        end

        // Screen boundaries.
        px_on(639, 479, ka);
        pix(640, 479, 1'b1, 1'b1, 1'b1, kb);
        pix(5, 480, 1'b1, 1'b1, 1'b1, kc);
        idle(4);
        wait_until(kc + 3);
        lit_map("addr_last_tile", ka + 1, 1199);
        lit("last_pixel", ka + 3, 24'h0000FA, 1'b1);
        lit_map("addr_x640", kb + 1, 0);
        lit("x640_out", kb + 3, 24'h0, 1'b0);
        lit("y480_out", kc + 3, 24'h0, 1'b0);

        // Reset in the middle of a line of visible wall pixels.
        for (int i = 0; i < 6; i++) px_on(16, 20 + i, k);
        bus.in_valid = 1'b0;
        bus.hs_in    = 1'b1;
        bus.vs_in    = 1'b1;
        #2 reset = 1'b1;
        exp_out.delete();
        exp_map.delete();
        m_bm = 16'h6FF6;
        #1;
        check("midline_reset_out", 32'({bus.red, bus.green, bus.blue, bus.out_valid,
                                        bus.hs_out, bus.vs_out}), 32'({24'h0, 3'b011}));
        check("midline_reset_map", 32'(bus.map_addr), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        // hs pulse on a pac pixel: the bitmap must be back to idle.
        pix(37, 45, 1'b1, 1'b0, 1'b1, kr);
        idle(5);
        wait_until(kr + 4);
        check("flush_c1", 32'(h_out[kr + 1][2:1]), 32'(2'b01));
        check("flush_c2", 32'(h_out[kr + 2][2:1]), 32'(2'b01));
        check("hs_align", 32'(h_out[kr + 3]), 32'({24'hFFFF00, 3'b101}));
        check("hs_after", 32'(h_out[kr + 4][1]), 32'd1);

        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
